mem_responder: RTL and testbench

//  Memory-side responder for the multicycle control unit. It accepts word read/write

---
 rtl/mem_responder_if.sv | 24 ++
 rtl/mem_responder.sv | 121 ++++++++++++
 tb/tb_mem_responder.sv | 329 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_responder_if.sv
// CPU-side request/response bundle between the multicycle control unit (master)
// and mem_responder (slave).
interface mem_responder_if #(
    parameter int DATA_W = 32
);
    logic              MemRead;
    logic              MemWrite;
    logic [31:0]       Address;
    logic [DATA_W-1:0] WriteData;
    logic [DATA_W-1:0] ReadData;
    logic              MemReady;
    logic              MemBusy;
    logic              MemError;

    modport master (
        output MemRead, MemWrite, Address, WriteData,
        input  ReadData, MemReady, MemBusy, MemError
    );

    modport slave (
        input  MemRead, MemWrite, Address, WriteData,
        output ReadData, MemReady, MemBusy, MemError
    );
endinterface

// File: rtl/mem_responder.sv
// Memory-side responder: sequences a fixed-latency synchronous RAM for the control unit.
// Optional build macro MEM_ALIGN_CHECK_EN rejects misaligned or out-of-range addresses.
module mem_responder #(
    parameter int ADDR_W      = 8,
    parameter int DATA_W      = 32,
    parameter int RAM_LATENCY = 1
) (
    input  logic              Clk,
    input  logic              Reset_PC,
    mem_responder_if.slave    bus,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [DATA_W-1:0] ram_wdata,
    output logic              ram_en,
    output logic              ram_we,
    input  logic [DATA_W-1:0] ram_rdata
);
    localparam int CNT_W = $clog2(RAM_LATENCY + 1);

    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_DONE} state_t;

    state_t            state;
    logic [CNT_W-1:0]  lat_cnt;
    logic              op_write;
    logic [DATA_W-1:0] read_data;
    logic              mem_ready;
    logic              mem_busy;
    logic              mem_error;
    logic              req_valid;
    logic              req_err;
    logic              addr_bad;

    assign req_valid = bus.MemRead | bus.MemWrite;

`ifdef MEM_ALIGN_CHECK_EN
    assign addr_bad = (bus.Address[1:0] != 2'b00) || (bus.Address[31:ADDR_W+2] != '0);
`else
    // Byte offset and upper bits are dropped so the word index wraps.
    logic unused_addr_bits;
    assign unused_addr_bits = ^{bus.Address[31:ADDR_W+2], bus.Address[1:0]};
    assign addr_bad         = 1'b0;
`endif

    assign req_err = (bus.MemRead & bus.MemWrite) | addr_bad;

    // NOTE: all state here uses non-blocking assignments so each branch sees pre-edge values.
    always_ff @(posedge Clk) begin
        if (!Reset_PC) begin
            state     <= S_IDLE;
            lat_cnt   <= '0;
            op_write  <= 1'b0;
            read_data <= '0;
            mem_ready <= 1'b0;
            mem_busy  <= 1'b0;
            mem_error <= 1'b0;
            ram_addr  <= '0;
            ram_wdata <= '0;
            ram_en    <= 1'b0;
            ram_we    <= 1'b0;
        end else begin
            // RAM strobes and the completion strobe are single-cycle pulses.
            ram_en    <= 1'b0;
            ram_we    <= 1'b0;
            mem_ready <= 1'b0;

            case (state)
                S_IDLE: begin
                    if (req_valid) begin
                        ram_addr  <= bus.Address[ADDR_W+1:2];
                        ram_wdata <= bus.WriteData;
                        op_write  <= bus.MemWrite;
                        mem_busy  <= 1'b1;
                        if (req_err) begin
                            mem_ready <= 1'b1;
                            mem_error <= 1'b1;
                            state     <= S_DONE;
                        end else begin
                            ram_en <= 1'b1;
                            ram_we <= bus.MemWrite;
                            state  <= S_ISSUE;
                        end
                    end
                end

                S_ISSUE: begin
                    if (op_write) begin
                        mem_ready <= 1'b1;
                        mem_error <= 1'b0;
                        state     <= S_DONE;
                    end else begin
                        lat_cnt <= CNT_W'(RAM_LATENCY);
                        state   <= S_WAIT;
                    end
                end

                S_WAIT: begin
                    // Last count is the cycle ram_rdata is valid for this access.
                    lat_cnt <= lat_cnt - CNT_W'(1);
                    if (lat_cnt == CNT_W'(1)) begin
                        read_data <= ram_rdata;
                        mem_ready <= 1'b1;
                        mem_error <= 1'b0;
                        state     <= S_DONE;
                    end
                end

                S_DONE: begin
                    mem_busy  <= 1'b0;
                    mem_error <= 1'b0;
                    state     <= S_IDLE;
                end

                default: state <= S_IDLE;
            endcase
        end
    end

    assign bus.ReadData = read_data;
    assign bus.MemReady = mem_ready;
    assign bus.MemBusy  = mem_busy;
    assign bus.MemError = mem_error;
endmodule

// File: tb/tb_mem_responder.sv
// Bench for mem_responder: directed vector table, hand-written multi-cycle sequences
// and randomized requests checked against a transaction-level reference model.
`timescale 1ns/1ps
module tb_mem_responder;
    localparam int AW    = 8;
    localparam int DW    = 32;
    localparam int L     = 3;
    localparam int DEPTH = 1 << AW;
    localparam int NV    = 14;

`ifdef MEM_ALIGN_CHECK_EN
    localparam bit ALIGN = 1'b1;
`else
    localparam bit ALIGN = 1'b0;
`endif

    logic          Clk;
    logic          Reset_PC;
    logic [AW-1:0] ram_addr;
    logic [DW-1:0] ram_wdata;
    logic [DW-1:0] ram_rdata;
    logic          ram_en;
    logic          ram_we;

    int checks   = 0;
    int failures = 0;

    mem_responder_if #(.DATA_W(DW)) bus ();

    mem_responder #(.ADDR_W(AW), .DATA_W(DW), .RAM_LATENCY(L)) dut (
        .Clk      (Clk),
        .Reset_PC (Reset_PC),
        .bus      (bus),
        .ram_addr (ram_addr),
        .ram_wdata(ram_wdata),
        .ram_en   (ram_en),
        .ram_we   (ram_we),
        .ram_rdata(ram_rdata)
    );

    initial begin
        Clk = 1'b0;
        forever #5 Clk = ~Clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: time limit reached before summary");
        $fatal(1, "bench timeout");
    end

    // RAM model: data valid L cycles after ram_en, random junk on all other cycles.
    logic [DW-1:0] ram_mem [DEPTH];
    logic [DW-1:0] rd_pipe [L];

    always @(posedge Clk) begin
        if (!Reset_PC) begin
            for (int i = 0; i < DEPTH; i++) ram_mem[i] <= 32'hA500_0000 | i;
        end else if (ram_en && ram_we) begin
            ram_mem[ram_addr] <= ram_wdata;
        end
        rd_pipe[0] <= (ram_en && !ram_we) ? ram_mem[ram_addr] : $urandom;
        for (int i = 1; i < L; i++) rd_pipe[i] <= rd_pipe[i-1];
    end

    assign ram_rdata = rd_pipe[L-1];

    // Reference model: one call per request, outcome computed from the request rules.
    typedef struct {
        logic        err;
        int          lat;
        int          idx;
        logic [31:0] rdata;
    } exp_t;

    logic [DW-1:0] model_mem [DEPTH];
    logic [DW-1:0] model_rd;

    function automatic void model_reset();
        for (int i = 0; i < DEPTH; i++) model_mem[i] = 32'hA500_0000 | i;
        model_rd = '0;
    endfunction

    function automatic exp_t model_txn(input logic rd, input logic wr,
                                       input logic [31:0] addr, input logic [31:0] wdata);
        exp_t e;
        logic bad_addr;
        bad_addr = 1'b0;
        if (ALIGN) bad_addr = (addr % 4 != 0) || (addr / 4 / DEPTH != 0);
        e.err = (rd && wr) || bad_addr;
        e.idx = int'((addr / 4) % DEPTH);
        if (e.err) begin
            e.lat = 1;
        end else if (wr) begin
            e.lat = 2;
            model_mem[e.idx] = wdata;
        end else begin
            e.lat = L + 2;
            model_rd = model_mem[e.idx];
        end
        e.rdata = model_rd;
        return e;
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic check_reset_state(input string tag);
        check({tag, " ReadData"}, 64'(bus.ReadData), 64'h0);
        check({tag, " MemReady"}, 64'(bus.MemReady), 64'h0);
        check({tag, " MemBusy"},  64'(bus.MemBusy),  64'h0);
        check({tag, " MemError"}, 64'(bus.MemError), 64'h0);
        check({tag, " ram_addr"}, 64'(ram_addr),     64'h0);
        check({tag, " ram_wdata"},64'(ram_wdata),    64'h0);
        check({tag, " ram_en"},   64'(ram_en),       64'h0);
        check({tag, " ram_we"},   64'(ram_we),       64'h0);
    endtask

    typedef struct {
        int   lat;
        logic err;
        int   en_cnt;
        int   we_cnt;
        int   issue_idx;
        int   done_idx;
        logic busy_ok;
    } obs_t;

    // Request held until MemReady; Address/WriteData scrambled while busy.
    task automatic run_txn(input logic rd, input logic wr, input logic [31:0] addr,
                           input logic [31:0] wdata, output obs_t o);
        o.lat = -1; o.err = 1'bx; o.en_cnt = 0; o.we_cnt = 0;
        o.issue_idx = -1; o.done_idx = -1; o.busy_ok = 1'b1;
        bus.MemRead = rd; bus.MemWrite = wr; bus.Address = addr; bus.WriteData = wdata;
        for (int c = 1; c <= L + 10; c++) begin
            @(posedge Clk); #1;
            bus.Address   = $urandom;
            bus.WriteData = $urandom;
            if (ram_en) begin
                o.en_cnt++;
                o.issue_idx = int'(ram_addr);
            end
            if (ram_we) o.we_cnt++;
            if (!bus.MemBusy) o.busy_ok = 1'b0;
            if (bus.MemReady) begin
                o.lat      = c;
                o.err      = bus.MemError;
                o.done_idx = int'(ram_addr);
                break;
            end
        end
        bus.MemRead  = 1'b0;
        bus.MemWrite = 1'b0;
    endtask

    task automatic check_txn(input string tag, input logic rd, input logic wr,
                             input logic [31:0] addr, input logic [31:0] wdata, input exp_t e);
        obs_t o;
        run_txn(rd, wr, addr, wdata, o);
        check({tag, " latency"},  64'(o.lat),    64'(e.lat));
        check({tag, " MemError"}, 64'(o.err),    64'(e.err));
        check({tag, " ram_en pulses"}, 64'(o.en_cnt), e.err ? 64'd0 : 64'd1);
        check({tag, " ram_we pulses"}, 64'(o.we_cnt), (!e.err && wr) ? 64'd1 : 64'd0);
        if (!e.err) begin
            check({tag, " issue index"}, 64'(o.issue_idx), 64'(e.idx));
            check({tag, " held index"},  64'(o.done_idx),  64'(e.idx));
        end
        check({tag, " ReadData"}, 64'(bus.ReadData), 64'(e.rdata));
        check({tag, " busy while active"}, 64'(o.busy_ok), 64'd1);
        @(posedge Clk); #1;
        check({tag, " MemReady one cycle"}, 64'(bus.MemReady), 64'd0);
        check({tag, " MemBusy back to idle"}, 64'(bus.MemBusy), 64'd0);
    endtask

    typedef struct {
        logic        rd;
        logic        wr;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic        err;
        int          lat;
        int          idx;
        logic [31:0] rdata;
    } vec_t;

    function automatic vec_t mk(input logic rd, input logic wr, input logic [31:0] addr,
                                input logic [31:0] wdata, input logic err, input int lat,
                                input int idx, input logic [31:0] rdata);
        vec_t v;
        v.rd = rd; v.wr = wr; v.addr = addr; v.wdata = wdata;
        v.err = err; v.lat = lat; v.idx = idx; v.rdata = rdata;
        return v;
    endfunction

    vec_t vecs [NV];

    initial begin
        int   strobes;
        int   stray;
        int   n_wait;
        exp_t e1;
        exp_t e2;

        Reset_PC      = 1'b0;
        bus.MemRead   = 1'b0;
        bus.MemWrite  = 1'b0;
        bus.Address   = '0;
        bus.WriteData = '0;
        repeat (3) @(posedge Clk);
        #1;
        check_reset_state("reset");
        Reset_PC = 1'b1;
        @(posedge Clk); #1;

        // Reset in the middle of a read aborts it silently.
        bus.MemRead = 1'b1;
        bus.Address = 32'h10;
        repeat (2) @(posedge Clk);
        #1;
        check("midread busy", 64'(bus.MemBusy), 64'd1);
        Reset_PC    = 1'b0;
        bus.MemRead = 1'b0;
        @(posedge Clk); #1;
        check_reset_state("abort c1");
        @(posedge Clk); #1;
        check_reset_state("abort c2");
        Reset_PC = 1'b1;
        strobes = 0;
        stray   = 0;
        repeat (L + 6) begin
            @(posedge Clk); #1;
            if (bus.MemReady) strobes++;
            if (ram_en || bus.MemBusy) stray++;
        end
        check("abort no MemReady", 64'(strobes), 64'd0);
        check("abort stays idle",  64'(stray),   64'd0);

        model_reset();
        vecs[0]  = mk(0, 1, 32'h10,  32'hDEAD_BEEF, 0, 2,     4,   32'h0);
        vecs[1]  = mk(1, 0, 32'h10,  32'h0,         0, L + 2, 4,   32'hDEAD_BEEF);
        vecs[2]  = mk(0, 1, 32'h20,  32'h1234_5678, 0, 2,     8,   32'hDEAD_BEEF);
        vecs[3]  = mk(1, 1, 32'h20,  32'h5555_5555, 1, 1,     8,   32'hDEAD_BEEF);
        vecs[4]  = mk(1, 0, 32'h20,  32'h0,         0, L + 2, 8,   32'h1234_5678);
        vecs[5]  = mk(0, 1, 32'h12,  32'hCAFE_F00D, ALIGN, ALIGN ? 1 : 2, 4, 32'h1234_5678);
        vecs[6]  = mk(1, 0, 32'h10,  32'h0,         0, L + 2, 4,
                      ALIGN ? 32'hDEAD_BEEF : 32'hCAFE_F00D);
        vecs[7]  = mk(0, 1, 32'h414, 32'h0BAD_C0DE, ALIGN, ALIGN ? 1 : 2, 5,
                      ALIGN ? 32'hDEAD_BEEF : 32'hCAFE_F00D);
        vecs[8]  = mk(1, 0, 32'h14,  32'h0,         0, L + 2, 5,
                      ALIGN ? 32'hA500_0005 : 32'h0BAD_C0DE);
        vecs[9]  = mk(1, 0, 32'h3FC, 32'h0,         0, L + 2, 255, 32'hA500_00FF);
        vecs[10] = mk(0, 1, 32'h3FC, 32'hFFFF_FFFF, 0, 2,     255, 32'hA500_00FF);
        vecs[11] = mk(1, 0, 32'h3FC, 32'h0,         0, L + 2, 255, 32'hFFFF_FFFF);
        vecs[12] = mk(0, 1, 32'h0,   32'h0000_0001, 0, 2,     0,   32'hFFFF_FFFF);
        vecs[13] = mk(1, 0, 32'h0,   32'h0,         0, L + 2, 0,   32'h0000_0001);

        for (int i = 0; i < NV; i++) begin
            exp_t e;
            void'(model_txn(vecs[i].rd, vecs[i].wr, vecs[i].addr, vecs[i].wdata));
            e.err   = vecs[i].err;
            e.lat   = vecs[i].lat;
            e.idx   = vecs[i].idx;
            e.rdata = vecs[i].rdata;
            check_txn($sformatf("vec%0d", i), vecs[i].rd, vecs[i].wr,
                      vecs[i].addr, vecs[i].wdata, e);
        end

        // Held MemRead through DONE: captured address stays put, next read starts after DONE.
        e1 = model_txn(1'b1, 1'b0, 32'h10, 32'h0);
        bus.MemRead = 1'b1;
        bus.Address = 32'h10;
        @(posedge Clk); #1;
        check("b2b first ram_en", 64'(ram_en),   64'd1);
        check("b2b first index",  64'(ram_addr), 64'd4);
        n_wait = 1;
        while (!bus.MemReady && n_wait < L + 10) begin
            bus.Address = (n_wait % 2 == 0) ? 32'h30 : 32'h34;
            @(posedge Clk); #1;
            n_wait++;
        end
        check("b2b first latency",  64'(n_wait),        64'(L + 2));
        check("b2b index held",     64'(ram_addr),      64'd4);
        check("b2b first ReadData", 64'(bus.ReadData),  64'(e1.rdata));
        e2 = model_txn(1'b1, 1'b0, 32'h20, 32'h0);
        bus.Address = 32'h20;
        @(posedge Clk); #1;
        check("b2b idle gap busy",   64'(bus.MemBusy), 64'd0);
        check("b2b idle gap ram_en", 64'(ram_en),      64'd0);
        @(posedge Clk); #1;
        check("b2b second ram_en", 64'(ram_en),   64'd1);
        check("b2b second index",  64'(ram_addr), 64'd8);
        bus.MemRead = 1'b0;
        bus.Address = $urandom;
        n_wait = 0;
        while (!bus.MemReady && n_wait < L + 10) begin
            @(posedge Clk); #1;
            n_wait++;
        end
        check("b2b second latency",  64'(n_wait),       64'(L + 1));
        check("b2b second ReadData", 64'(bus.ReadData), 64'(e2.rdata));
        @(posedge Clk); #1;

        for (int n = 0; n < 60; n++) begin
            logic        rd;
            logic        wr;
            logic [31:0] a;
            logic [31:0] d;
            int          k;
            exp_t        e;
            k  = $urandom_range(0, 9);
            rd = (k < 4) || (k >= 8);
            wr = (k >= 4);
            a  = 32'($urandom_range(0, 15)) << 2;
            if ($urandom_range(0, 4) == 0) a = a | ($urandom & 32'hFFFF_FC00);
            if ($urandom_range(0, 4) == 0) a = a | 32'($urandom_range(1, 3));
            d = $urandom;
            e = model_txn(rd, wr, a, d);
            check_txn($sformatf("rnd%0d", n), rd, wr, a, d, e);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
